// File: rtl/instr_fetch_if.sv
// Load-port and fetch-port signal bundle for instr_fetch.
// master = loader/processor side, slave = instr_fetch.
interface instr_fetch_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 9;

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic              cpu_en;
  logic [1:0]        state;
  logic [CNT_W-1:0]  ld_count;
  logic              err;

  modport master (
    output ld_valid, ld_data, ld_last, pc,
    input  ld_ready, instr, cpu_en, state, ld_count, err
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, pc,
    output ld_ready, instr, cpu_en, state, ld_count, err
  );
endinterface

// File: rtl/instr_fetch.sv
// Loadable 256x8 instruction store feeding a processor with a one-cycle fetch.
// Define IFETCH_BOUND_CHECK_EN to trap fetches beyond the loaded program in FAULT.
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  instr_fetch_if.slave bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned CNT_W  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    RUN   = 2'b10,
    FAULT = 2'b11
  } state_e;

  state_e            state_q, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  ld_count_q, ld_count_n;
  logic [DATA_W-1:0] instr_q, instr_n;
  logic              ld_ready_q;
  logic              cpu_en_q;
  logic              accept_c;
  logic              oob_c;

  // ld_ready_q tracks IDLE/LOAD exactly, so it doubles as the write qualifier
  assign accept_c = bus.ld_valid && ld_ready_q;

`ifdef IFETCH_BOUND_CHECK_EN
  assign oob_c = (state_q == RUN) && ({1'b0, bus.pc} >= ld_count_q);
`else
  assign oob_c = 1'b0;
`endif

  // Next-state, load counter and fetch data
  always_comb begin
    state_n    = state_q;
    ld_count_n = ld_count_q;
    instr_n    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          ld_count_n = ld_count_q + CNT_W'(1);
          state_n    = bus.ld_last ? RUN : LOAD;
        end
      end
      LOAD: begin
        if (accept_c) begin
          ld_count_n = ld_count_q + CNT_W'(1);
          if (bus.ld_last || (ld_count_q == CNT_W'(DEPTH - 1))) begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (oob_c) begin
          state_n = FAULT;
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (state_n == RUN) begin
      instr_n = mem[bus.pc];
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_count_q <= '0;
      instr_q    <= '0;
      ld_ready_q <= 1'b1;
      cpu_en_q   <= 1'b0;
    end else begin
      state_q    <= state_n;
      ld_count_q <= ld_count_n;
      instr_q    <= instr_n;
      ld_ready_q <= (state_n == IDLE) || (state_n == LOAD);
      cpu_en_q   <= (state_n == RUN);
    end
  end

  // Program store; reset wipes it so a new program always starts from zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else if (accept_c) begin
      mem[ld_count_q[ADDR_W-1:0]] <= bus.ld_data;
    end
  end

`ifdef IFETCH_BOUND_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_n == FAULT);
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.state    = state_q;
  assign bus.ld_count = ld_count_q;
  assign bus.instr    = instr_q;
  assign bus.ld_ready = ld_ready_q;
  assign bus.cpu_en   = cpu_en_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: load sequences, fetch scoreboard, reset and range cases.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst;

  instr_fetch_if bus ();

  instr_fetch u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_mem [256];
  int         exp_count;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    exp_count = 0;
  endtask

  // One accepted load beat; the bench model stores it at the current count
  task automatic load_byte(input logic [7:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    exp_mem[exp_count] = d;
    exp_count++;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // Drive PC, push the expected word, pop and compare one edge later
  task automatic fetch(input logic [7:0] p, input logic [7:0] e);
    logic [7:0] want;
    bus.pc = p;
    exp_q.push_back(e);
    tick();
    want = exp_q.pop_front();
    check("instr", 32'(bus.instr), 32'(want));
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_state", 32'(bus.state), 32'h0);
    check("rst_count", 32'(bus.ld_count), 32'h0);
    tick();
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    rst          = 1'b1;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 8'h00;
    bus.ld_last  = 1'b0;
    bus.pc       = 8'h00;
    clear_model();
    #1;
    check("rst_state",    32'(bus.state),    32'h0);
    check("rst_count",    32'(bus.ld_count), 32'h0);
    check("rst_instr",    32'(bus.instr),    32'h0);
    check("rst_cpu_en",   32'(bus.cpu_en),   32'h0);
    check("rst_err",      32'(bus.err),      32'h0);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'h1);
    tick();
    rst = 1'b0;

    // Three-byte program ending with ld_last
    load_byte(8'h41, 1'b0);
    check("load1_state", 32'(bus.state), 32'h1);
    check("load1_count", 32'(bus.ld_count), 32'd1);
    check("load1_instr", 32'(bus.instr), 32'h0);
    load_byte(8'h82, 1'b0);
    load_byte(8'hC3, 1'b1);
    check("run_count",    32'(bus.ld_count), 32'd3);
    check("run_state",    32'(bus.state),    32'h2);
    check("run_cpu_en",   32'(bus.cpu_en),   32'h1);
    check("run_ld_ready", 32'(bus.ld_ready), 32'h0);
    check("run_err",      32'(bus.err),      32'h0);
    for (int i = 0; i < 3; i++) fetch(8'(i), exp_mem[i]);

    // Load beat in RUN must be ignored
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hFF;
    bus.ld_last  = 1'b1;
    bus.pc       = 8'h00;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    check("run_ld_ignored_count", 32'(bus.ld_count), 32'd3);
    fetch(8'h00, 8'h41);
    fetch(8'h01, 8'h82);
    fetch(8'h03, 8'h00);
`ifdef IFETCH_BOUND_CHECK_EN
    check("oob_state",  32'(bus.state),  32'h3);
    check("oob_err",    32'(bus.err),    32'h1);
    check("oob_cpu_en", 32'(bus.cpu_en), 32'h0);
    fetch(8'h00, 8'h00);
    check("fault_hold", 32'(bus.state), 32'h3);
`else
    check("oob_state",  32'(bus.state),  32'h2);
    check("oob_err",    32'(bus.err),    32'h0);
    check("oob_cpu_en", 32'(bus.cpu_en), 32'h1);
`endif

    // Asynchronous reset part-way through a load
    do_reset();
    load_byte(8'h5A, 1'b0);
    load_byte(8'hA5, 1'b0);
    check("mid_count", 32'(bus.ld_count), 32'd2);
    #3 rst = 1'b1;
    #1;
    check("async_state", 32'(bus.state), 32'h0);
    check("async_count", 32'(bus.ld_count), 32'h0);
    check("async_ready", 32'(bus.ld_ready), 32'h1);
    tick();
    rst = 1'b0;
    clear_model();
    load_byte(8'h11, 1'b1);
    check("reload_state", 32'(bus.state), 32'h2);
    check("reload_count", 32'(bus.ld_count), 32'd1);
    fetch(8'h00, 8'h11);
`ifndef IFETCH_BOUND_CHECK_EN
    fetch(8'h01, 8'h00);
    fetch(8'h02, 8'h00);
`endif

    // Full 256-byte program without ld_last, with a stall mid-load
    do_reset();
    bus.pc = 8'h00;
    for (int i = 0; i < 256; i++) begin
      load_byte(8'(i), 1'b0);
      if (i == 10) begin
        tick();
        tick();
        check("stall_state", 32'(bus.state), 32'h1);
        check("stall_count", 32'(bus.ld_count), 32'd11);
      end
      if (i == 254) begin
        check("pre_full_state", 32'(bus.state), 32'h1);
        check("pre_full_count", 32'(bus.ld_count), 32'd255);
      end
    end
    check("full_state", 32'(bus.state), 32'h2);
    check("full_count", 32'(bus.ld_count), 32'd256);
    check("full_ready", 32'(bus.ld_ready), 32'h0);
    fetch(8'hFF, exp_mem[255]);
    fetch(8'h80, exp_mem[128]);
    fetch(8'h00, exp_mem[0]);
    bus.ld_valid = 1'b1;
    tick();
    bus.ld_valid = 1'b0;
    check("full_no_wrap", 32'(bus.ld_count), 32'd256);

    if (exp_q.size() != 0) check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
